// File: rtl/jt10_adpcm_pkg.sv
// rtl/jt10_adpcm_pkg.sv - shared types and defaults for the ADPCM ROM bridge
package jt10_adpcm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_A = 2'd1,
    REQ_B = 2'd2
  } bridge_state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
    logic        valid;
  } tag_t;

  localparam logic [24:0] DEF_A_BASE = 25'h000_0000;
  localparam logic [24:0] DEF_B_BASE = 25'h100_0000;

endpackage

// File: rtl/jt10_adpcm_rom_port.sv
// rtl/jt10_adpcm_rom_port.sv - per-channel strobe detect, one-entry tag and data register
module jt10_adpcm_rom_port
  import jt10_adpcm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] addr,
  input  logic        roe_n,
  input  logic        fetch_done,
  input  logic [23:0] fetch_addr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  data,
  output logic [23:0] req_addr,
  output logic        pend
);

  logic        roe_l;
  logic [23:0] addr_l;
  logic        chk;
  tag_t        tag;
  logic        trigger;
  logic        hit;
  logic        fill;

  assign trigger = !roe_n && (roe_l || (addr != addr_l));
  assign hit     = tag.valid && (tag.addr == req_addr);
  // A fetch only satisfies the channel if the chip still wants that byte
  assign fill    = fetch_done && (fetch_addr == req_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roe_l    <= 1'b1;
      addr_l   <= '0;
      chk      <= 1'b0;
      req_addr <= '0;
      tag      <= '0;
      data     <= '0;
      pend     <= 1'b0;
    end else begin
      roe_l  <= roe_n;
      addr_l <= addr;
      chk    <= trigger;
      if (trigger)
        req_addr <= addr;
      if (fetch_done) begin
        tag.addr  <= fetch_addr;
        tag.data  <= mem_din;
        tag.valid <= 1'b1;
      end
      if (fill) begin
        data <= mem_din;
        pend <= 1'b0;
      end
      if (chk && !fill) begin
        if (hit) begin
          data <= tag.data;
          pend <= 1'b0;
        end else begin
          pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jt10_adpcm_rom_bridge.sv
// rtl/jt10_adpcm_rom_bridge.sv - YM2610 ADPCM ROM pins to shared byte memory port bridge
module jt10_adpcm_rom_bridge
  import jt10_adpcm_pkg::*;
#(
  parameter int            AW     = 25,
  parameter logic [AW-1:0] A_BASE = AW'(DEF_A_BASE),
  parameter logic [AW-1:0] B_BASE = AW'(DEF_B_BASE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [19:0]   adpcma_addr,
  input  logic [3:0]    adpcma_bank,
  input  logic          adpcma_roe_n,
  output logic [7:0]    adpcma_data,
  input  logic [23:0]   adpcmb_addr,
  input  logic          adpcmb_roe_n,
  output logic [7:0]    adpcmb_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [7:0]    mem_din,
  output logic          busy
);

  bridge_state_t state, state_nx;
  logic          ptr_b;
  logic          grant_a, grant_b;
  logic          pend_a, pend_b;
  logic [23:0]   req_a, req_b;
  logic [23:0]   fetch_addr;
  logic          done_a, done_b;

  assign done_a = (state == REQ_A) && mem_ack;
  assign done_b = (state == REQ_B) && mem_ack;

  jt10_adpcm_rom_port u_port_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       ({adpcma_bank, adpcma_addr}),
    .roe_n      (adpcma_roe_n),
    .fetch_done (done_a),
    .fetch_addr (fetch_addr),
    .mem_din    (mem_din),
    .data       (adpcma_data),
    .req_addr   (req_a),
    .pend       (pend_a)
  );

  jt10_adpcm_rom_port u_port_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (adpcmb_addr),
    .roe_n      (adpcmb_roe_n),
    .fetch_done (done_b),
    .fetch_addr (fetch_addr),
    .mem_din    (mem_din),
    .data       (adpcmb_data),
    .req_addr   (req_b),
    .pend       (pend_b)
  );

  always_comb begin
    state_nx = state;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_a && pend_b) begin
          grant_a = !ptr_b;
          grant_b = ptr_b;
        end else begin
          grant_a = pend_a;
          grant_b = pend_b;
        end
        if (grant_a)
          state_nx = REQ_A;
        else if (grant_b)
          state_nx = REQ_B;
      end
      REQ_A, REQ_B: begin
        if (mem_ack)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pointer only moves on contested grants; a lone request leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr_b      <= 1'b0;
      mem_addr   <= '0;
      fetch_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pend_a && pend_b)
        ptr_b <= !ptr_b;
      if (grant_a) begin
        mem_addr   <= A_BASE + AW'(req_a);
        fetch_addr <= req_a;
      end else if (grant_b) begin
        mem_addr   <= B_BASE + AW'(req_b);
        fetch_addr <= req_b;
      end
    end
  end

  assign mem_req = (state != IDLE);
  assign busy    = pend_a || pend_b || (state != IDLE);

endmodule

// File: tb/tb_jt10_adpcm_rom_bridge.sv
// tb/tb_jt10_adpcm_rom_bridge.sv - directed self-checking bench for jt10_adpcm_rom_bridge
module tb_jt10_adpcm_rom_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] adpcma_addr;
  logic [3:0]  adpcma_bank;
  logic        adpcma_roe_n;
  logic [7:0]  adpcma_data;
  logic [23:0] adpcmb_addr;
  logic        adpcmb_roe_n;
  logic [7:0]  adpcmb_data;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_din;
  logic        busy;

  logic [19:0] wa_addr;
  logic [3:0]  wa_bank;
  logic        wa_roe_n;
  logic [7:0]  wa_data;
  logic [23:0] wb_addr;
  logic        wb_roe_n;
  logic [7:0]  wb_data;
  logic [24:0] w_mem_addr;
  logic        w_mem_req;
  logic        w_mem_ack;
  logic        w_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jt10_adpcm_rom_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .adpcma_addr(adpcma_addr), .adpcma_bank(adpcma_bank), .adpcma_roe_n(adpcma_roe_n),
    .adpcma_data(adpcma_data),
    .adpcmb_addr(adpcmb_addr), .adpcmb_roe_n(adpcmb_roe_n), .adpcmb_data(adpcmb_data),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_din(mem_din),
    .busy(busy)
  );

  jt10_adpcm_rom_bridge #(.B_BASE(25'h1FF_FFFF)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .adpcma_addr(wa_addr), .adpcma_bank(wa_bank), .adpcma_roe_n(wa_roe_n),
    .adpcma_data(wa_data),
    .adpcmb_addr(wb_addr), .adpcmb_roe_n(wb_roe_n), .adpcmb_data(wb_data),
    .mem_addr(w_mem_addr), .mem_req(w_mem_req), .mem_ack(w_mem_ack), .mem_din(mem_din),
    .busy(w_busy)
  );

  typedef struct packed {
    logic        roe_a;
    logic [3:0]  bank;
    logic [19:0] addr_a;
    logic        ack;
    logic [7:0]  din;
    logic        e_req;
    logic [24:0] e_addr;
    logic [7:0]  e_a;
    logic        e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name, input logic [24:0] exp_addr);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_req"}, 32'(mem_req), 32'd1);
    check({name, "_addr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  task automatic pulse_ack(input logic [7:0] d, input int delay);
    repeat (delay) @(negedge clk);
    mem_ack = 1'b1;
    mem_din = d;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_din = 8'h00;
  endtask

  task automatic serve(input string name, input logic [24:0] exp_addr, input logic [7:0] d);
    wait_req(name, exp_addr);
    pulse_ack(d, 1);
    check({name, "_drop"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    adpcma_addr = '0; adpcma_bank = '0; adpcma_roe_n = 1'b1;
    adpcmb_addr = '0; adpcmb_roe_n = 1'b1;
    mem_ack = 1'b0; mem_din = '0;
    wa_addr = '0; wa_bank = '0; wa_roe_n = 1'b1;
    wb_addr = '0; wb_roe_n = 1'b1; w_mem_ack = 1'b0;

    // roe_a, bank, addr, ack, din | req, mem_addr, adpcma_data, busy
    vecs[0]  = '{1'b1, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b0, 25'h000_0000, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b0, 25'h000_0000, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b0, 25'h000_0000, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b1, 25'h020_0010, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b1, 25'h020_0010, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b1, 25'h020_0010, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 4'h2, 20'h00010, 1'b1, 8'h5A, 1'b0, 25'h020_0010, 8'h5A, 1'b0};
    vecs[7]  = '{1'b1, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b0, 25'h020_0010, 8'h5A, 1'b0};
    vecs[8]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b0, 25'h020_0010, 8'h5A, 1'b0};
    vecs[9]  = '{1'b0, 4'h2, 20'h00010, 1'b0, 8'h00, 1'b0, 25'h020_0010, 8'h5A, 1'b0};
    vecs[10] = '{1'b1, 4'h2, 20'h00010, 1'b1, 8'hFF, 1'b0, 25'h020_0010, 8'h5A, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_a", 32'(adpcma_data), 32'd0);
    check("rst_b", 32'(adpcmb_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      adpcma_roe_n = vecs[i].roe_a;
      adpcma_bank  = vecs[i].bank;
      adpcma_addr  = vecs[i].addr_a;
      mem_ack      = vecs[i].ack;
      mem_din      = vecs[i].din;
      @(negedge clk);
      check($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_a", i), 32'(adpcma_data), 32'(vecs[i].e_a));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end
    mem_ack = 1'b0;
    mem_din = 8'h00;

    // simultaneous misses, pointer starts at A
    adpcma_bank = 4'h0; adpcma_addr = 20'h00100; adpcmb_addr = 24'h000100;
    @(negedge clk);
    adpcma_roe_n = 1'b0; adpcmb_roe_n = 1'b0;
    serve("pair1_a", 25'h000_0100, 8'hA1);
    check("pair1_a_data", 32'(adpcma_data), 32'h0A1);
    serve("pair1_b", 25'h100_0100, 8'hB1);
    check("pair1_b_data", 32'(adpcmb_data), 32'h0B1);
    check("pair1_busy", 32'(busy), 32'd0);

    adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
    adpcma_addr = 20'h00200; adpcmb_addr = 24'h000200;
    @(negedge clk);
    adpcma_roe_n = 1'b0; adpcmb_roe_n = 1'b0;
    serve("pair2_b", 25'h100_0200, 8'hB2);
    check("pair2_b_data", 32'(adpcmb_data), 32'h0B2);
    serve("pair2_a", 25'h000_0200, 8'hA2);
    check("pair2_a_data", 32'(adpcma_data), 32'h0A2);

    // address moves while the fetch is in flight
    adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
    @(negedge clk);
    adpcma_roe_n = 1'b0; adpcma_bank = 4'h2; adpcma_addr = 20'h00010;
    wait_req("mid1", 25'h020_0010);
    adpcma_addr = 20'h00011;
    @(negedge clk);
    pulse_ack(8'h11, 0);
    check("mid_stale_a", 32'(adpcma_data), 32'h0A2);
    check("mid_stale_busy", 32'(busy), 32'd1);
    serve("mid2", 25'h020_0011, 8'h22);
    check("mid_new_a", 32'(adpcma_data), 32'h022);
    check("mid_idle_busy", 32'(busy), 32'd0);

    // wrap past 2^AW on the B region
    wb_addr = 24'h000002;
    @(negedge clk);
    wb_roe_n = 1'b0;
    begin
      int n = 0;
      while (!w_mem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("wrap_req", 32'(w_mem_req), 32'd1);
    check("wrap_addr", 32'(w_mem_addr), 32'h000_0001);
    w_mem_ack = 1'b1; mem_din = 8'h77;
    @(negedge clk);
    w_mem_ack = 1'b0; mem_din = 8'h00;
    check("wrap_data", 32'(wb_data), 32'h077);

    // reset while REQ_B is outstanding
    adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1; adpcmb_addr = 24'h000300;
    @(negedge clk);
    adpcmb_roe_n = 1'b0;
    wait_req("rstb", 25'h100_0300);
    rst_n = 1'b0;
    #1;
    check("rstmid_req", 32'(mem_req), 32'd0);
    check("rstmid_a", 32'(adpcma_data), 32'd0);
    check("rstmid_b", 32'(adpcmb_data), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    adpcmb_roe_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    adpcma_roe_n = 1'b0;
    serve("post_rst", 25'h020_0011, 8'h33);
    check("post_rst_a", 32'(adpcma_data), 32'h033);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt10_adpcm_rom_bridge.md
Name: jt10_adpcm_rom_bridge

Overview:
- Sits directly downstream of the YM2610 ADPCM ROM pins (adpcma_addr/bank/roe_n, adpcmb_addr/roe_n).
- Converts each ROM read strobe into a request on a single shared byte-wide memory port (SDRAM controller side), then returns the byte on adpcma_data/adpcmb_data.
- Holds a one-entry tag per channel so repeated reads of the same byte cost no memory cycle.
- Arbitrates A/B round-robin.

Parameters:
- AW, 25, memory byte-address width.
- A_BASE, 25'h000_0000, memory offset of the ADPCM-A region.
- B_BASE, 25'h100_0000, memory offset of the ADPCM-B region.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- adpcma_addr  in  20  ADPCM-A byte address
- adpcma_bank  in  4  ADPCM-A bank
- adpcma_roe_n  in  1  ADPCM-A ROM output enable, active-low
- adpcma_data  out  8  ADPCM-A byte to chip
- adpcmb_addr  in  24  ADPCM-B byte address
- adpcmb_roe_n  in  1  ADPCM-B ROM output enable, active-low
- adpcmb_data  out  8  ADPCM-B byte to chip
- mem_addr  out  AW  memory byte address
- mem_req  out  1  request, held high until ack
- mem_ack  in  1  one-cycle pulse; mem_din valid in the same cycle
- mem_din  in  8  memory read data
- busy  out  1  any pending or in-flight fetch

Behaviour:
- Reset (async, rst_n=0): adpcma_data=0, adpcmb_data=0, mem_req=0, mem_addr=0, busy=0, FSM=IDLE, tags invalid, pending flags clear, round-robin pointer=A.
- Request detect, per channel, evaluated every clk:
  - Trigger on a roe_n falling edge (registered previous value).
  - Also trigger when the full address changes while roe_n=0 (A uses {bank,addr}).
  - A trigger latches the full address into req_addr_x.
- Hit: tag valid and tag address == req_addr_x → data_x <= tag data on the next clk; no memory cycle, no pending flag.
- Miss: set pend_x.
- Memory address mapping, modulo 2^AW (wrap, no saturation):
  - A: A_BASE + {bank,addr} zero-extended.
  - B: B_BASE + addr zero-extended.
- FSM states: IDLE, REQ_A, REQ_B.
  - IDLE → REQ_x when pend_x is set.
  - Both pending: pick the channel the round-robin pointer names; pointer flips to the other channel after each grant.
  - On entering REQ_x: mem_req=1 and mem_addr is registered and held stable until mem_ack.
  - REQ_x on mem_ack:
    - Write tag_x = {fetched address, mem_din, valid}.
    - If fetched address == current req_addr_x: data_x <= mem_din on the next clk and pend_x is cleared.
    - Otherwise (address changed mid-flight): data_x is unchanged and pend_x stays set, so the fetch is reissued.
    - mem_req drops the cycle after ack; return to IDLE (one idle cycle minimum between requests).
- Latency: ack-to-data is 1 clk; hit is 2 clk from the roe_n edge.
- A new trigger on one channel never aborts the other channel's in-flight request.
- mem_ack outside REQ_x is ignored.
- roe_n rising has no effect; data_x holds its last value.
- busy = pend_a | pend_b | (FSM != IDLE).
- Reset asserted mid-request: mem_req drops immediately (async). The memory controller must tolerate an abandoned request.

Decomposition:
- Shared package jt10_adpcm_pkg holds:
  - FSM state enum (IDLE/REQ_A/REQ_B).
  - Tag struct {addr, data, valid}.
  - Default A_BASE/B_BASE constants.
- One sub-module, jt10_adpcm_rom_port, instantiated twice (channel A with 24-bit {bank,addr}, channel B with 24-bit addr). It contains the edge detect, request latch, tag compare, pending flag and data register.
- The top level holds the arbiter FSM and the address mapping.

Test Plan:
- A miss: bank=4'h2, addr=20'h00010, roe_n falls; memory acks after 3 clk with 8'h5A → mem_addr=25'h020_0010, adpcma_data=8'h5A one clk after ack, busy falls.
- A hit: repeat the same address after another roe_n edge → no mem_req; adpcma_data=8'h5A 2 clk after the edge.
- Simultaneous A and B misses, pointer=A: A granted first, then B (B_BASE+24'h000100 → 25'h100_0100); next simultaneous pair grants B first.
- Address change mid-flight: A addr moves 20'h00010→20'h00011 before ack of 8'h11 → adpcma_data unchanged, second request at 25'h020_0011, data updated only on its ack.
- Wrap: B_BASE=25'h1FF_FFFF, addr=24'h000002 → mem_addr=25'h000_0001.
- Reset during REQ_B: rst_n low → mem_req=0, both data outputs=0, tags invalid; a post-reset request is a miss.
